ecc_scrub_ctrl: RTL and testbench
=================================

# ecc_scrub_ctrl

Downstream consumer of the 64-bit SEC-DED decoder on the cache read path. Each cycle it can take one decoded word (corrected data, syndrome, ERR/SGL/DBL) and register it as a read response. On a single-bit error it writes the corrected word back to the array through a request/acknowledge handshake. It also keeps saturating error counters, a first-error log and a sticky double-error interrupt.

## Interface
- AW, 10, cache array word-address width
- CW, 16, error counter width
- CLK  in  1  clock, all state on rising edge
- RST  in  1  reset, asynchronous, active-high
- RD_VLD  in  1  decoded read word valid this cycle
- RD_ADDR  in  AW  array address of the word
- DATA  in  64  corrected data from decoder (OUT[63:0])
- SYN  in  8  decoder syndrome
- ERR, SGL, DBL  in  1 each  decoder flags
- RSP_VLD  out  1  registered response valid
- RSP_DATA  out  64  registered corrected data
- RSP_ERR  out  1  response is uncorrectable (DBL)
- WB_REQ  out  1  scrub write-back request
- WB_ADDR  out  AW  write-back address
- WB_DATA  out  64  write-back data, re-encoded by the array-side encoder
- WB_ACK  in  1  array accepted write-back
- BUSY  out  1  scrub in progress; advisory to the upstream read issuer
- SEC_CNT  out  CW  corrected-error count, saturating
- DED_CNT  out  CW  uncorrectable-error count, saturating
- CNT_CLR  in  1  synchronous clear of both counters
- LOG_VLD  out  1  log holds an entry
- LOG_ADDR  out  AW  logged address
- LOG_SYN  out  8  logged syndrome
- LOG_DBL  out  1  logged entry is a double error
- LOG_CLR  in  1  synchronous clear of log and IRQ
- IRQ  out  1  sticky double-error interrupt

## Operation
- Reset values: all outputs 0. FSM is in IDLE.
- Response path:
  - Every cycle, RSP_VLD<=RD_VLD and RSP_DATA<=DATA.
  - RSP_ERR<=RD_VLD&DBL.
  - Response and counting apply regardless of FSM state.
- Counters:
  - RD_VLD&SGL increments SEC_CNT. RD_VLD&DBL increments DED_CNT.
  - Both counters hold at all-ones.
  - CNT_CLR forces 0 and wins over a same-cycle increment.
- FSM states: IDLE, WB.
  - IDLE -> WB on RD_VLD&SGL. In the same edge, capture RD_ADDR into WB_ADDR and DATA into WB_DATA.
  - WB: WB_REQ=1 and BUSY=1. WB_ADDR and WB_DATA are held stable.
  - WB -> IDLE on the edge where WB_ACK=1. WB_ACK in IDLE is ignored.
  - SGL arriving while in WB is responded to and counted but not scrubbed. No queueing.
- DBL never triggers a write-back.
- ERR without SGL or DBL is treated as no error.
- Log:
  - Empty log + RD_VLD&ERR(SGL or DBL) → LOG_VLD=1 and capture address, syndrome and LOG_DBL.
  - A DBL event overwrites an entry with LOG_DBL=0 (one upgrade only).
  - SGL never overwrites.
  - LOG_CLR empties the log. A capture-worthy event in the same cycle is captured (new entry wins).
- IRQ: set on RD_VLD&DBL, cleared by LOG_CLR. Set wins over a same-cycle clear.

## Timing
- Response latency is 1 cycle: RD_VLD at edge n gives RSP_VLD high after edge n, for one cycle per accepted word.
- Scrub timing: SGL sampled at edge n → WB_REQ/BUSY high after edge n. If WB_ACK is sampled at edge n+1, WB_REQ drops after n+1, so the minimum request is one cycle.
- Back-to-back scrubs: the next scrub can start on the edge that exits WB only if it comes from IDLE sampling. An SGL sampled on the exit edge itself is not scrubbed.
- BUSY is registered (equals state==WB). Upstream may still issue a read in the first BUSY cycle; that read is handled as above.
- Counter and log updates are visible 1 cycle after the event.
- RST mid-scrub: WB_REQ, BUSY, counters, log and IRQ go to 0 asynchronously and the pending scrub is abandoned. Outputs stay 0 until the first edge after RST deasserts.

## Test plan
- Clean read: RD_VLD=1, ERR=0, DATA=64'h0123_4567_89AB_CDEF → next cycle RSP_VLD=1 with the same data, RSP_ERR=0, WB_REQ=0, counters 0, LOG_VLD=0.
- Single-bit error at RD_ADDR=10'h05A with SYN=8'h23 and WB_ACK delayed 3 cycles:
  - SEC_CNT=1, LOG_ADDR=10'h05A, LOG_SYN=8'h23, LOG_DBL=0.
  - WB_REQ high for exactly 4 cycles with WB_ADDR/WB_DATA constant, then BUSY=0.
- SGL on addr 1, then SGL on addr 2 the next cycle while in WB:
  - Both responses are issued and SEC_CNT=2.
  - Only addr 1 is written back. The log stays at addr 1.
- SGL (addr 3), then DBL (addr 4, SYN=8'h0F):
  - Log upgrades to addr 4, LOG_DBL=1. IRQ=1, DED_CNT=1, RSP_ERR=1 on the second response.
  - No write-back for addr 4.
  - A later DBL does not overwrite the log.
- Saturation and clears, with CW=4:
  - 17 SGL reads → SEC_CNT=4'hF.
  - CNT_CLR coincident with an SGL → SEC_CNT=0.
  - LOG_CLR coincident with a DBL → LOG_VLD=1 with the new entry and IRQ stays 1.
- Reset mid-scrub: assert RST while WB_REQ=1 → WB_REQ, BUSY, SEC_CNT and IRQ read 0 immediately, before the next clock edge. After release, FSM is in IDLE and WB_ACK is ignored.

Source files
------------

// File: rtl/ecc_scrub_ctrl_if.sv
// ecc_scrub_ctrl_if
//   Bundles the decoded-read input, the registered read response, the
//   scrub write-back handshake and the error counter/log status of
//   ecc_scrub_ctrl.
//   master : read issuer / array / status consumer (drives rd_*, wb_ack, clears)
//   slave  : ecc_scrub_ctrl
interface ecc_scrub_ctrl_if #(
    parameter int AW = 10,
    parameter int CW = 16
);
    // decoded read word
    logic          rd_vld;
    logic [AW-1:0] rd_addr;
    logic [63:0]   data;
    logic [7:0]    syn;
    logic          err;
    logic          sgl;
    logic          dbl;
    // read response
    logic          rsp_vld;
    logic [63:0]   rsp_data;
    logic          rsp_err;
    // scrub write-back
    logic          wb_req;
    logic [AW-1:0] wb_addr;
    logic [63:0]   wb_data;
    logic          wb_ack;
    logic          busy;
    // counters / log / interrupt
    logic [CW-1:0] sec_cnt;
    logic [CW-1:0] ded_cnt;
    logic          cnt_clr;
    logic          log_vld;
    logic [AW-1:0] log_addr;
    logic [7:0]    log_syn;
    logic          log_dbl;
    logic          log_clr;
    logic          irq;

    modport master (
        output rd_vld, rd_addr, data, syn, err, sgl, dbl, wb_ack, cnt_clr, log_clr,
        input  rsp_vld, rsp_data, rsp_err, wb_req, wb_addr, wb_data, busy,
               sec_cnt, ded_cnt, log_vld, log_addr, log_syn, log_dbl, irq
    );

    modport slave (
        input  rd_vld, rd_addr, data, syn, err, sgl, dbl, wb_ack, cnt_clr, log_clr,
        output rsp_vld, rsp_data, rsp_err, wb_req, wb_addr, wb_data, busy,
               sec_cnt, ded_cnt, log_vld, log_addr, log_syn, log_dbl, irq
    );
endinterface

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl
//   Consumer of the 64-bit SEC-DED decoder on the cache read path.
//   - Registers every decoded word as a read response (1-cycle latency).
//   - On a single-bit error, writes the corrected word back to the array
//     through a req/ack handshake (one scrub at a time, no queueing).
//   - Keeps saturating SEC/DED counters, a first-error log with a single
//     upgrade to a double error, and a sticky double-error interrupt.
// Ports
//   i_clk : clock, all state on rising edge
//   i_rst : asynchronous active-high reset
//   bus   : ecc_scrub_ctrl_if.slave (read, response, write-back, status)
module ecc_scrub_ctrl #(
    parameter int AW = 10,
    parameter int CW = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    ecc_scrub_ctrl_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, WB = 1'b1} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_wb_req;
    logic          w_busy;

    logic          r_rsp_vld;
    logic [63:0]   r_rsp_data;
    logic          r_rsp_err;
    logic [AW-1:0] r_wb_addr;
    logic [63:0]   r_wb_data;
    logic [CW-1:0] r_sec_cnt;
    logic [CW-1:0] r_ded_cnt;
    logic          r_log_vld;
    logic [AW-1:0] r_log_addr;
    logic [7:0]    r_log_syn;
    logic          r_log_dbl;
    logic          r_irq;

    logic          w_sgl;
    logic          w_dbl;
    logic          w_log_ev;
    logic          w_log_cap;

    assign w_sgl    = bus.rd_vld & bus.sgl;
    assign w_dbl    = bus.rd_vld & bus.dbl;
    // ERR alone (no SGL/DBL) is not an error and never reaches the log
    assign w_log_ev = bus.rd_vld & bus.err & (bus.sgl | bus.dbl);
    // capture into an empty (or just-cleared) log, or upgrade a single-error
    // entry to a double once; a double entry is never replaced
    assign w_log_cap = w_log_ev &
                       (bus.log_clr | ~r_log_vld |
                        (~r_log_dbl & bus.dbl));

    // ---------------- scrub FSM ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_sgl)      w_state_nxt = WB;
            WB:      if (bus.wb_ack) w_state_nxt = IDLE;
            default:                 w_state_nxt = IDLE;
        endcase
    end

    // outputs decode straight from the state register, so BUSY is registered
    always_comb begin
        w_wb_req = 1'b0;
        w_busy   = 1'b0;
        if (r_state == WB) begin
            w_wb_req = 1'b1;
            w_busy   = 1'b1;
        end
    end

    // write-back payload is loaded only on the IDLE->WB edge and held in WB
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (r_state == IDLE && w_sgl) begin
            r_wb_addr <= bus.rd_addr;
            r_wb_data <= bus.data;
        end
    end

    // ---------------- response path ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rsp_vld  <= 1'b0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
        end else begin
            r_rsp_vld  <= bus.rd_vld;
            r_rsp_data <= bus.data;
            r_rsp_err  <= w_dbl;
        end
    end

    // ---------------- counters ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else if (bus.cnt_clr) begin
            r_sec_cnt <= '0;
            r_ded_cnt <= '0;
        end else begin
            if (w_sgl && r_sec_cnt != '1) r_sec_cnt <= r_sec_cnt + 1'b1;
            if (w_dbl && r_ded_cnt != '1) r_ded_cnt <= r_ded_cnt + 1'b1;
        end
    end

    // ---------------- log / irq ----------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_log_vld  <= 1'b0;
            r_log_addr <= '0;
            r_log_syn  <= '0;
            r_log_dbl  <= 1'b0;
        end else if (w_log_cap) begin
            r_log_vld  <= 1'b1;
            r_log_addr <= bus.rd_addr;
            r_log_syn  <= bus.syn;
            r_log_dbl  <= bus.dbl;
        end else if (bus.log_clr) begin
            r_log_vld  <= 1'b0;
            r_log_dbl  <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)             r_irq <= 1'b0;
        else if (w_dbl)        r_irq <= 1'b1;
        else if (bus.log_clr)  r_irq <= 1'b0;
    end

    assign bus.rsp_vld  = r_rsp_vld;
    assign bus.rsp_data = r_rsp_data;
    assign bus.rsp_err  = r_rsp_err;
    assign bus.wb_req   = w_wb_req;
    assign bus.busy     = w_busy;
    assign bus.wb_addr  = r_wb_addr;
    assign bus.wb_data  = r_wb_data;
    assign bus.sec_cnt  = r_sec_cnt;
    assign bus.ded_cnt  = r_ded_cnt;
    assign bus.log_vld  = r_log_vld;
    assign bus.log_addr = r_log_addr;
    assign bus.log_syn  = r_log_syn;
    assign bus.log_dbl  = r_log_dbl;
    assign bus.irq      = r_irq;

endmodule

// File: tb/tb_ecc_scrub_ctrl.sv
// tb_ecc_scrub_ctrl
//   Directed bench for ecc_scrub_ctrl with AW=10, CW=4. Inputs change 1ns
//   after a rising edge; outputs are checked 1ns after the edge that
//   should have produced them.
module tb_ecc_scrub_ctrl;
    localparam int AW = 10;
    localparam int CW = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;
    int   req_cycles;

    ecc_scrub_ctrl_if #(.AW(AW), .CW(CW)) bus ();

    ecc_scrub_ctrl #(.AW(AW), .CW(CW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic vld, input logic [AW-1:0] addr, input logic [63:0] d,
                      input logic [7:0] s, input logic sg, input logic db);
        bus.rd_vld  = vld;
        bus.rd_addr = addr;
        bus.data    = d;
        bus.syn     = s;
        bus.err     = sg | db;
        bus.sgl     = sg;
        bus.dbl     = db;
    endtask

    task automatic idle();
        rd(1'b0, '0, 64'hDEAD_BEEF_DEAD_BEEF, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b1;
        idle();
        bus.wb_ack  = 1'b0;
        bus.cnt_clr = 1'b0;
        bus.log_clr = 1'b0;
        #2;
        chk("rst_rsp_vld", 64'(bus.rsp_vld), 64'd0);
        chk("rst_wb_req",  64'(bus.wb_req),  64'd0);
        chk("rst_busy",    64'(bus.busy),    64'd0);
        chk("rst_sec",     64'(bus.sec_cnt), 64'd0);
        chk("rst_log_vld", 64'(bus.log_vld), 64'd0);
        chk("rst_irq",     64'(bus.irq),     64'd0);
        tick();
        rst = 1'b0;
        tick();

        // ---- clean read ----
        rd(1'b1, 10'h010, 64'h0123_4567_89AB_CDEF, 8'h00, 1'b0, 1'b0);
        tick();
        chk("clean_rsp_vld",  64'(bus.rsp_vld), 64'd1);
        chk("clean_rsp_data", bus.rsp_data,     64'h0123_4567_89AB_CDEF);
        chk("clean_rsp_err",  64'(bus.rsp_err), 64'd0);
        chk("clean_wb_req",   64'(bus.wb_req),  64'd0);
        chk("clean_sec",      64'(bus.sec_cnt), 64'd0);
        chk("clean_ded",      64'(bus.ded_cnt), 64'd0);
        chk("clean_log_vld",  64'(bus.log_vld), 64'd0);
        // ERR without SGL/DBL is not an error
        rd(1'b1, 10'h011, 64'h1, 8'h55, 1'b0, 1'b0);
        bus.err = 1'b1;
        tick();
        idle();
        chk("erronly_log_vld", 64'(bus.log_vld), 64'd0);
        chk("erronly_wb_req",  64'(bus.wb_req),  64'd0);
        tick();
        chk("idle_rsp_vld", 64'(bus.rsp_vld), 64'd0);

        // ---- single-bit error, ack after 3 extra cycles ----
        rd(1'b1, 10'h05A, 64'hCAFE_0000_1111_2222, 8'h23, 1'b1, 1'b0);
        tick();
        idle();
        chk("sgl_sec",      64'(bus.sec_cnt),  64'd1);
        chk("sgl_log_vld",  64'(bus.log_vld),  64'd1);
        chk("sgl_log_addr", 64'(bus.log_addr), 64'h05A);
        chk("sgl_log_syn",  64'(bus.log_syn),  64'h23);
        chk("sgl_log_dbl",  64'(bus.log_dbl),  64'd0);
        chk("sgl_busy",     64'(bus.busy),     64'd1);
        req_cycles = bus.wb_req ? 1 : 0;
        for (int k = 0; k < 3; k++) begin
            chk("sgl_wb_addr", 64'(bus.wb_addr), 64'h05A);
            chk("sgl_wb_data", bus.wb_data,      64'hCAFE_0000_1111_2222);
            tick();
            if (bus.wb_req) req_cycles++;
        end
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        if (bus.wb_req) req_cycles++;
        chk("sgl_req_cycles", 64'(req_cycles), 64'd4);
        chk("sgl_busy_end",   64'(bus.busy),   64'd0);

        // ---- SGL while in WB is not scrubbed ----
        bus.log_clr = 1'b1;
        bus.cnt_clr = 1'b1;
        tick();
        bus.log_clr = 1'b0;
        bus.cnt_clr = 1'b0;
        chk("clr_log_vld", 64'(bus.log_vld), 64'd0);
        chk("clr_sec",     64'(bus.sec_cnt), 64'd0);
        rd(1'b1, 10'h001, 64'hA1, 8'h11, 1'b1, 1'b0);
        tick();
        chk("b2b_rsp1",    bus.rsp_data,       64'hA1);
        chk("b2b_wb_req",  64'(bus.wb_req),    64'd1);
        rd(1'b1, 10'h002, 64'hA2, 8'h22, 1'b1, 1'b0);
        tick();
        idle();
        chk("b2b_rsp2_vld", 64'(bus.rsp_vld),  64'd1);
        chk("b2b_rsp2",     bus.rsp_data,      64'hA2);
        chk("b2b_sec",      64'(bus.sec_cnt),  64'd2);
        chk("b2b_wb_addr",  64'(bus.wb_addr),  64'h001);
        chk("b2b_wb_data",  bus.wb_data,       64'hA1);
        chk("b2b_log_addr", 64'(bus.log_addr), 64'h001);
        chk("b2b_log_syn",  64'(bus.log_syn),  64'h11);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        chk("b2b_done", 64'(bus.wb_req), 64'd0);
        tick();
        chk("b2b_no_second", 64'(bus.wb_req), 64'd0);

        // ---- SGL then DBL: log upgrade ----
        bus.log_clr = 1'b1;
        bus.cnt_clr = 1'b1;
        tick();
        bus.log_clr = 1'b0;
        bus.cnt_clr = 1'b0;
        rd(1'b1, 10'h003, 64'hB3, 8'h33, 1'b1, 1'b0);
        tick();
        chk("up_log_addr1", 64'(bus.log_addr), 64'h003);
        rd(1'b1, 10'h004, 64'hB4, 8'h0F, 1'b0, 1'b1);
        tick();
        idle();
        chk("up_rsp_err",  64'(bus.rsp_err),  64'd1);
        chk("up_ded",      64'(bus.ded_cnt),  64'd1);
        chk("up_irq",      64'(bus.irq),      64'd1);
        chk("up_log_addr", 64'(bus.log_addr), 64'h004);
        chk("up_log_syn",  64'(bus.log_syn),  64'h0F);
        chk("up_log_dbl",  64'(bus.log_dbl),  64'd1);
        chk("up_wb_addr",  64'(bus.wb_addr),  64'h003);
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        rd(1'b1, 10'h007, 64'hB7, 8'h77, 1'b0, 1'b1);
        tick();
        idle();
        chk("dbl2_log_addr", 64'(bus.log_addr), 64'h004);
        chk("dbl2_log_syn",  64'(bus.log_syn),  64'h0F);
        chk("dbl2_ded",      64'(bus.ded_cnt),  64'd2);
        chk("dbl2_no_wb",    64'(bus.wb_req),   64'd0);

        // ---- saturation and clears ----
        for (int k = 0; k < 17; k++) begin
            rd(1'b1, AW'(k + 32), 64'(k), 8'h01, 1'b1, 1'b0);
            tick();
        end
        idle();
        chk("sat_sec",  64'(bus.sec_cnt),  64'hF);
        chk("sat_log",  64'(bus.log_addr), 64'h004);
        bus.cnt_clr = 1'b1;
        rd(1'b1, 10'h0AA, 64'hAA, 8'h02, 1'b1, 1'b0);
        tick();
        bus.cnt_clr = 1'b0;
        idle();
        chk("cclr_sec", 64'(bus.sec_cnt), 64'd0);
        chk("cclr_ded", 64'(bus.ded_cnt), 64'd0);
        bus.log_clr = 1'b1;
        rd(1'b1, 10'h009, 64'h99, 8'h99, 1'b0, 1'b1);
        tick();
        bus.log_clr = 1'b0;
        idle();
        chk("lclr_log_vld",  64'(bus.log_vld),  64'd1);
        chk("lclr_log_addr", 64'(bus.log_addr), 64'h009);
        chk("lclr_log_syn",  64'(bus.log_syn),  64'h99);
        chk("lclr_log_dbl",  64'(bus.log_dbl),  64'd1);
        chk("lclr_irq",      64'(bus.irq),      64'd1);
        bus.log_clr = 1'b1;
        tick();
        bus.log_clr = 1'b0;
        chk("lclr2_log_vld", 64'(bus.log_vld), 64'd0);
        chk("lclr2_irq",     64'(bus.irq),     64'd0);

        // ---- reset mid-scrub ----
        rd(1'b1, 10'h011, 64'h11, 8'h03, 1'b1, 1'b0);
        tick();
        rd(1'b1, 10'h012, 64'h12, 8'h04, 1'b0, 1'b1);
        tick();
        idle();
        chk("pre_rst_wb_req", 64'(bus.wb_req),  64'd1);
        chk("pre_rst_sec",    64'(bus.sec_cnt), 64'd1);
        chk("pre_rst_irq",    64'(bus.irq),     64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wb_req",  64'(bus.wb_req),  64'd0);
        chk("arst_busy",    64'(bus.busy),    64'd0);
        chk("arst_sec",     64'(bus.sec_cnt), 64'd0);
        chk("arst_irq",     64'(bus.irq),     64'd0);
        chk("arst_log_vld", 64'(bus.log_vld), 64'd0);
        tick();
        rst = 1'b0;
        bus.wb_ack = 1'b1;
        tick();
        bus.wb_ack = 1'b0;
        chk("post_rst_ack_ign", 64'(bus.wb_req), 64'd0);
        rd(1'b1, 10'h021, 64'h21, 8'h05, 1'b1, 1'b0);
        tick();
        idle();
        chk("post_rst_scrub",   64'(bus.wb_req),  64'd1);
        chk("post_rst_wb_addr", 64'(bus.wb_addr), 64'h021);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
